sram_wr_coalescer: RTL and testbench

- Upstream write-side stage for the QDR SRAM controller. Accepts single 144-bit write beats, each with its own address and byte enables.
- Merges runs of consecutive addresses into bursts. Drives the controller's usr_wreq_sram / usr_wcnt_sram / sram_awrdy_usr / sram_dwrdy_usr write handshake.
- Buffers beats and burst descriptors so that a client writing one beat at a time gets burst efficiency.

---
 rtl/sram_wr_coalescer.sv | 180 ++++++++++++++++++
 tb/tb_sram_wr_coalescer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wr_coalescer.sv
`timescale 1ns/1ps
// sram_wr_coalescer: merges single 144-bit write beats into address-contiguous bursts for the QDR SRAM controller.
// Define SRAM_WR_COALESCER_STATS_EN to add the stat_bursts / stat_beats counters.
module sram_wr_coalescer #(
    parameter int ADDR_WIDTH      = 22,
    parameter int DATA_WIDTH      = 144,
    parameter int BW_WIDTH        = 16,
    parameter int MAX_BURST       = 16,
    parameter int DATA_FIFO_DEPTH = 32,
    parameter int DESC_FIFO_DEPTH = 8,
    parameter int FLUSH_CYCLES    = 8
) (
    input  logic                  memclk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [BW_WIDTH-1:0]   in_bw,
    output logic                  usr_wreq_sram,
    output logic [7:0]            usr_wcnt_sram,
    output logic [ADDR_WIDTH-1:0] usr_waddr_sram,
    output logic [DATA_WIDTH-1:0] usr_wdata_sram,
    output logic [BW_WIDTH-1:0]   usr_bw_sram,
    input  logic                  sram_awrdy_usr,
    input  logic                  sram_dwrdy_usr,
`ifdef SRAM_WR_COALESCER_STATS_EN
    output logic [31:0]           stat_bursts,
    output logic [31:0]           stat_beats,
`endif
    output logic                  busy
);
    localparam int DA_W       = $clog2(DATA_FIFO_DEPTH);
    localparam int DE_W       = $clog2(DESC_FIFO_DEPTH);
    localparam int IDLE_W     = $clog2(FLUSH_CYCLES + 1);
    localparam int DATA_ENT_W = BW_WIDTH + DATA_WIDTH;
    localparam int DESC_ENT_W = ADDR_WIDTH + 8;
    localparam logic [DA_W:0]       DATA_CAP = (DA_W+1)'(DATA_FIFO_DEPTH);
    localparam logic [DE_W:0]       DESC_CAP = (DE_W+1)'(DESC_FIFO_DEPTH);
    localparam logic [8:0]          LEN_MAX  = 9'(MAX_BURST);
    localparam logic [IDLE_W-1:0]   IDLE_MAX = IDLE_W'(FLUSH_CYCLES);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [DATA_ENT_W-1:0] r_dmem [DATA_FIFO_DEPTH];
    logic [DA_W-1:0]       r_dwp, r_drp;
    logic [DA_W:0]         r_dcnt;
    logic [DESC_ENT_W-1:0] r_qmem [DESC_FIFO_DEPTH];
    logic [DE_W-1:0]       r_qwp, r_qrp;
    logic [DE_W:0]         r_qcnt;

    logic                  r_alive;
    logic                  r_run_open;
    logic [ADDR_WIDTH-1:0] r_run_addr;
    logic [8:0]            r_run_len;
    logic [IDLE_W-1:0]     r_idle;
    state_t                r_state;
    logic [7:0]            r_rem;

    logic                  w_data_full, w_data_empty, w_desc_full, w_desc_empty;
    logic                  w_accept, w_contig, w_run_full, w_flush, w_close_push;
    logic                  w_desc_push, w_wreq, w_data_pop;
    logic [8:0]            w_run_end;
    logic [DESC_ENT_W-1:0] w_desc_in, w_desc_head;
    logic [DATA_ENT_W-1:0] w_data_head;

    assign w_data_full  = (r_dcnt == DATA_CAP);
    assign w_data_empty = (r_dcnt == '0);
    assign w_desc_full  = (r_qcnt == DESC_CAP);
    assign w_desc_empty = (r_qcnt == '0);
    assign in_ready     = r_alive && !w_data_full && !w_desc_full;
    assign w_accept     = in_valid && in_ready;

    // End offset is 9 bits wide so a run ending at 0xFF never looks contiguous with offset 0x00.
    assign w_run_end    = {1'b0, r_run_addr[7:0]} + r_run_len;
    assign w_contig     = r_run_open
                       && (in_addr[ADDR_WIDTH-1:8] == r_run_addr[ADDR_WIDTH-1:8])
                       && ({1'b0, in_addr[7:0]} == w_run_end)
                       && (r_run_len < LEN_MAX);
    assign w_run_full   = r_run_open && ((r_run_len == LEN_MAX) || (w_run_end == 9'd256));
    assign w_flush      = r_run_open && (r_idle == IDLE_MAX);
    assign w_close_push = !w_accept && (w_run_full || w_flush) && !w_desc_full;
    assign w_desc_push  = (w_accept && r_run_open && !w_contig) || w_close_push;
    assign w_desc_in    = {r_run_addr, 8'(r_run_len - 9'd1)};

    assign w_desc_head  = r_qmem[r_qrp];
    assign w_data_head  = r_dmem[r_drp];
    assign w_wreq       = (r_state == S_IDLE) && !w_desc_empty && sram_awrdy_usr;
    assign w_data_pop   = w_wreq || ((r_state == S_BURST) && sram_dwrdy_usr && (r_rem != 8'd0));

    assign usr_wreq_sram  = w_wreq;
    assign usr_waddr_sram = w_desc_empty ? '0 : w_desc_head[DESC_ENT_W-1:8];
    assign usr_wcnt_sram  = w_desc_empty ? '0 : w_desc_head[7:0];
    assign usr_wdata_sram = w_data_head[DATA_WIDTH-1:0];
    assign usr_bw_sram    = w_data_head[DATA_ENT_W-1:DATA_WIDTH];
    assign busy           = r_run_open || !w_data_empty || !w_desc_empty || (r_state != S_IDLE);

    // NOTE: storage arrays carry no reset; the occupancy counters alone decide which entries are valid.
    always_ff @(posedge memclk) begin
        if (w_accept)    r_dmem[r_dwp] <= {in_bw, in_data};
        if (w_desc_push) r_qmem[r_qwp] <= w_desc_in;
    end

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            r_dwp  <= '0;
            r_drp  <= '0;
            r_dcnt <= '0;
            r_qwp  <= '0;
            r_qrp  <= '0;
            r_qcnt <= '0;
        end else begin
            if (w_accept)    r_dwp <= r_dwp + 1'b1;
            if (w_data_pop)  r_drp <= r_drp + 1'b1;
            r_dcnt <= r_dcnt + (DA_W+1)'(w_accept) - (DA_W+1)'(w_data_pop);
            if (w_desc_push) r_qwp <= r_qwp + 1'b1;
            if (w_wreq)      r_qrp <= r_qrp + 1'b1;
            r_qcnt <= r_qcnt + (DE_W+1)'(w_desc_push) - (DE_W+1)'(w_wreq);
        end
    end

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            r_alive    <= 1'b0;
            r_run_open <= 1'b0;
            r_run_addr <= '0;
            r_run_len  <= '0;
            r_idle     <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_run_open <= 1'b1;
                r_idle     <= '0;
                if (w_contig) begin
                    r_run_len <= r_run_len + 9'd1;
                end else begin
                    r_run_addr <= in_addr;
                    r_run_len  <= 9'd1;
                end
            end else if (w_close_push) begin
                r_run_open <= 1'b0;
                r_idle     <= '0;
            end else if (r_run_open && (r_idle != IDLE_MAX)) begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_wreq) begin
                    r_rem   <= w_desc_head[7:0];
                    r_state <= S_BURST;
                end
                S_BURST: if (sram_dwrdy_usr) begin
                    if (r_rem != 8'd0) r_rem   <= r_rem - 8'd1;
                    else               r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SRAM_WR_COALESCER_STATS_EN
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            stat_bursts <= '0;
            stat_beats  <= '0;
        end else begin
            if (w_wreq)     stat_bursts <= stat_bursts + 32'd1;
            if (w_data_pop) stat_beats  <= stat_beats + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_wr_coalescer.sv
`timescale 1ns/1ps
// tb_sram_wr_coalescer: directed and randomized bench; a controller-side monitor reassembles delivered beats
// and compares them with the submitted stream and with expected burst splits.
module tb_sram_wr_coalescer;
    localparam int AW   = 22;
    localparam int DW   = 144;
    localparam int BWW  = 16;
    localparam int MAXB = 16;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [BWW-1:0] bw;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    cnt;
    } burst_t;

    logic           memclk = 1'b0;
    logic           reset  = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [AW-1:0]  in_addr = '0;
    logic [DW-1:0]  in_data = '0;
    logic [BWW-1:0] in_bw = '0;
    logic           usr_wreq_sram;
    logic [7:0]     usr_wcnt_sram;
    logic [AW-1:0]  usr_waddr_sram;
    logic [DW-1:0]  usr_wdata_sram;
    logic [BWW-1:0] usr_bw_sram;
    logic           sram_awrdy_usr = 1'b1;
    logic           sram_dwrdy_usr = 1'b1;
    logic           busy;
`ifdef SRAM_WR_COALESCER_STATS_EN
    logic [31:0]    stat_bursts, stat_beats;
`endif

    sram_wr_coalescer dut (
        .memclk         (memclk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .in_bw          (in_bw),
        .usr_wreq_sram  (usr_wreq_sram),
        .usr_wcnt_sram  (usr_wcnt_sram),
        .usr_waddr_sram (usr_waddr_sram),
        .usr_wdata_sram (usr_wdata_sram),
        .usr_bw_sram    (usr_bw_sram),
        .sram_awrdy_usr (sram_awrdy_usr),
        .sram_dwrdy_usr (sram_dwrdy_usr),
`ifdef SRAM_WR_COALESCER_STATS_EN
        .stat_bursts    (stat_bursts),
        .stat_beats     (stat_beats),
`endif
        .busy           (busy)
    );

    always #5 memclk = ~memclk;

    int     errors = 0;
    int     checks = 0;
    bit     rand_ctl = 0;
    beat_t  exp_q[$];
    beat_t  got_q[$];
    burst_t bq[$];

    // Controller-side view: a request carries beat 0, then each dwrdy cycle with beats left carries one more.
    bit            m_act = 0;
    int            m_rem = 0;
    int            m_idx = 0;
    logic [AW-1:0] m_base = '0;
    int            wreq_in_burst = 0;

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input int idx);
        return {base[AW-1:8], base[7:0] + 8'(idx)};
    endfunction

    always @(negedge memclk) begin
        if (reset) begin
            m_act = 0;
        end else if (m_act) begin
            if (usr_wreq_sram) wreq_in_burst++;
            if (sram_dwrdy_usr) begin
                if (m_rem > 0) begin
                    got_q.push_back('{beat_addr(m_base, m_idx), usr_wdata_sram, usr_bw_sram});
                    m_idx++;
                    m_rem--;
                end else begin
                    m_act = 0;
                end
            end
        end else if (usr_wreq_sram) begin
            bq.push_back('{usr_waddr_sram, usr_wcnt_sram});
            m_base = usr_waddr_sram;
            m_rem  = int'(usr_wcnt_sram);
            m_idx  = 1;
            m_act  = 1;
            got_q.push_back('{usr_waddr_sram, usr_wdata_sram, usr_bw_sram});
        end
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge memclk);
        #1;
        if (rand_ctl) begin
            sram_awrdy_usr = ($urandom % 4) != 0;
            sram_dwrdy_usr = ($urandom % 3) != 0;
        end
    endtask

    function automatic beat_t rand_beat(input logic [AW-1:0] a);
        beat_t b;
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b.addr = a;
        b.data = r[DW-1:0];
        b.bw   = BWW'($urandom);
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_valid = 1'b1;
        in_addr  = b.addr;
        in_data  = b.data;
        in_bw    = b.bw;
    endtask

    task automatic send_beat(input logic [AW-1:0] a);
        beat_t b;
        bit    acc;
        int    n;
        b = rand_beat(a);
        drive(b);
        acc = 0;
        n = 0;
        while (!acc && n < 300) begin
            @(negedge memclk);
            acc = in_ready;
            step();
            n++;
        end
        if (!acc) chk("accept_timeout", 160'(acc), 160'(1));
        else exp_q.push_back(b);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || m_act) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 160'(busy || m_act), 160'(0));
    endtask

    task automatic chk_burst(input string tag, input int i, input logic [AW-1:0] a, input logic [7:0] c);
        if (i < bq.size()) begin
            chk({tag, "_waddr"}, 160'(bq[i].addr), 160'(a));
            chk({tag, "_wcnt"}, 160'(bq[i].cnt), 160'(c));
        end else begin
            chk({tag, "_missing_burst"}, 160'(bq.size()), 160'(i + 1));
        end
    endtask

    task automatic compare_beats(input string tag);
        chk({tag, "_nbeats"}, 160'(got_q.size()), 160'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_addr"}, 160'(got_q[i].addr), 160'(exp_q[i].addr));
            chk({tag, "_data"}, 160'(got_q[i].data), 160'(exp_q[i].data));
            chk({tag, "_bw"}, 160'(got_q[i].bw), 160'(exp_q[i].bw));
        end
        got_q.delete();
        exp_q.delete();
        bq.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            k, n;
        bit            acc;
        beat_t         b;
        logic [AW-1:0] a;
`ifdef SRAM_WR_COALESCER_STATS_EN
        logic [31:0]   s0;
`endif

        // Reset values
        repeat (3) @(posedge memclk);
        #1;
        chk("rst_in_ready", 160'(in_ready), 160'(0));
        chk("rst_wreq", 160'(usr_wreq_sram), 160'(0));
        chk("rst_wcnt", 160'(usr_wcnt_sram), 160'(0));
        chk("rst_waddr", 160'(usr_waddr_sram), 160'(0));
        chk("rst_busy", 160'(busy), 160'(0));
        reset = 1'b0;
        step();
        chk("ready_after_reset", 160'(in_ready), 160'(1));

        // Contiguous run closed by the idle flush
        for (int i = 0; i < 4; i++) send_beat(22'h000010 + AW'(i));
        idle(6);
        chk("t1_no_early_req", 160'(bq.size()), 160'(0));
        wait_quiet("t1", 200);
        chk("t1_nbursts", 160'(bq.size()), 160'(1));
        chk_burst("t1", 0, 22'h000010, 8'd3);
        compare_beats("t1");

        // Split at MAX_BURST
        for (int i = 0; i < 20; i++) send_beat(AW'(i));
        wait_quiet("t2", 300);
        chk("t2_nbursts", 160'(bq.size()), 160'(2));
        chk_burst("t2a", 0, 22'h000000, 8'd15);
        chk_burst("t2b", 1, 22'h000010, 8'd3);
        compare_beats("t2");

        // 256-word boundary
        send_beat(22'h0000FE);
        send_beat(22'h0000FF);
        send_beat(22'h000100);
        send_beat(22'h000101);
        wait_quiet("t3", 300);
        chk("t3_nbursts", 160'(bq.size()), 160'(2));
        chk_burst("t3a", 0, 22'h0000FE, 8'd1);
        chk_burst("t3b", 1, 22'h000100, 8'd1);
        compare_beats("t3");

        // Chip-select change and address gap
        send_beat(22'h000005);
        send_beat(22'h080006);
        wait_quiet("t4a", 300);
        chk("t4a_nbursts", 160'(bq.size()), 160'(2));
        chk_burst("t4a0", 0, 22'h000005, 8'd0);
        chk_burst("t4a1", 1, 22'h080006, 8'd0);
        compare_beats("t4a");
        send_beat(22'h000005);
        send_beat(22'h000007);
        wait_quiet("t4b", 300);
        chk("t4b_nbursts", 160'(bq.size()), 160'(2));
        chk_burst("t4b0", 0, 22'h000005, 8'd0);
        chk_burst("t4b1", 1, 22'h000007, 8'd0);
        compare_beats("t4b");

        // Backpressure: controller not ready while 40 beats are offered
`ifdef SRAM_WR_COALESCER_STATS_EN
        s0 = stat_beats;
`endif
        sram_awrdy_usr = 1'b0;
        k = 0;
        b = rand_beat(22'h000200);
        drive(b);
        for (int c = 0; c < 80; c++) begin
            @(negedge memclk);
            acc = in_ready;
            step();
            if (acc) begin
                exp_q.push_back(b);
                k++;
                b = rand_beat(22'h000200 + AW'(k));
                drive(b);
            end
        end
        in_valid = 1'b0;
        chk("t5_buffered", 160'(k), 160'(32));
        chk("t5_ready_low", 160'(in_ready), 160'(0));
        chk("t5_no_req", 160'(bq.size()), 160'(0));
        sram_awrdy_usr = 1'b1;
        for (int i = k; i < 40; i++) send_beat(22'h000200 + AW'(i));
        wait_quiet("t5", 500);
        chk("t5_nbursts", 160'(bq.size()), 160'(3));
        chk_burst("t5a", 0, 22'h000200, 8'd15);
        chk_burst("t5b", 1, 22'h000210, 8'd15);
        chk_burst("t5c", 2, 22'h000220, 8'd7);
        compare_beats("t5");
`ifdef SRAM_WR_COALESCER_STATS_EN
        chk("t5_stat_beats", 160'(stat_beats - s0), 160'(40));
`endif

        // Reset in the middle of a burst (rem = 5, second burst queued)
        sram_dwrdy_usr = 1'b0;
        for (int i = 0; i < 6; i++) send_beat(22'h000300 + AW'(i));
        send_beat(22'h000340);
        send_beat(22'h000341);
        idle(20);
        chk("t6_one_req", 160'(bq.size()), 160'(1));
        chk_burst("t6_first", 0, 22'h000300, 8'd5);
        chk("t6_pending_waddr", 160'(usr_waddr_sram), 160'(22'h000340));
        chk("t6_pending_wcnt", 160'(usr_wcnt_sram), 160'(1));
        chk("t6_busy_before", 160'(busy), 160'(1));
        reset = 1'b1;
        #1;
        chk("t6_rst_wreq", 160'(usr_wreq_sram), 160'(0));
        chk("t6_rst_wcnt", 160'(usr_wcnt_sram), 160'(0));
        chk("t6_rst_waddr", 160'(usr_waddr_sram), 160'(0));
        chk("t6_rst_busy", 160'(busy), 160'(0));
        chk("t6_rst_in_ready", 160'(in_ready), 160'(0));
        repeat (2) @(posedge memclk);
        #1;
        reset = 1'b0;
        sram_dwrdy_usr = 1'b1;
        got_q.delete();
        exp_q.delete();
        bq.delete();
        step();
        send_beat(22'h000400);
        wait_quiet("t6", 300);
        chk("t6_nbursts", 160'(bq.size()), 160'(1));
        chk_burst("t6_fresh", 0, 22'h000400, 8'd0);
        compare_beats("t6");

        // Randomized stream with random controller readiness
        rand_ctl = 1;
        a = AW'($urandom);
        for (int i = 0; i < 200; i++) begin
            n = int'($urandom % 8);
            if (n == 0) a = AW'($urandom);
            else if (n == 1) a[7:0] = 8'hFC;
            send_beat(a);
            a = a + 1'b1;
            if (($urandom % 10) == 0) idle(int'($urandom % 13));
        end
        idle(1);
        rand_ctl = 0;
        sram_awrdy_usr = 1'b1;
        sram_dwrdy_usr = 1'b1;
        wait_quiet("rnd", 3000);
        for (int i = 0; i < bq.size(); i++) begin
            chk("rnd_len_ok", 160'(bq[i].cnt < 8'(MAXB)), 160'(1));
            chk("rnd_page_ok", 160'(({1'b0, bq[i].addr[7:0]} + {1'b0, bq[i].cnt}) < 9'd256), 160'(1));
        end
        compare_beats("rnd");
        chk("wreq_during_burst", 160'(wreq_in_burst), 160'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
